// File: rtl/dispense_pkg.sv
// dispense_pkg: shared types and constants for the dispense stepper controller.
//   - FSM state encoding
//   - coil drive sequences for full-step and half-step operation
//   - PHASE_W / SEQ_LEN, chosen by the HALF_STEP_EN macro
//     (HALF_STEP_EN defined: 8-entry half-step sequence;
//      undefined: 4-entry full-step sequence)
package dispense_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_HOLD  = 2'd2,
    ST_FAULT = 2'd3
  } state_e;

  localparam logic [3:0] COIL_OFF = 4'b0000;

  // Index [0] is the first pattern driven after a load. Coil bits are {D,C,B,A}.
  localparam logic [3:0][3:0] FULL_SEQ = {4'b1001, 4'b1100, 4'b0110, 4'b0011};
  localparam logic [7:0][3:0] HALF_SEQ = {4'b1001, 4'b1000, 4'b1100, 4'b0100,
                                          4'b0110, 4'b0010, 4'b0011, 4'b0001};

`ifdef HALF_STEP_EN
  localparam int PHASE_W = 3;
`else
  localparam int PHASE_W = 2;
`endif
  // Phase counter width equals log2 of the sequence length, so the
  // phase wraps through the sequence by natural overflow.
  localparam int SEQ_LEN = 1 << PHASE_W;

  typedef logic [PHASE_W-1:0] phase_t;

  function automatic logic [3:0] seq_coil(phase_t ph);
`ifdef HALF_STEP_EN
    return HALF_SEQ[ph];
`else
    return FULL_SEQ[ph];
`endif
  endfunction

endpackage

// File: rtl/dispense_step_ctrl_if.sv
// dispense_step_ctrl_if: request/status bus between the vend controller
// (master) and dispense_step_ctrl (slave).
//   req_i    dispense request level
//   steps_i  requested step count (STEPS_W bits)
//   abort_i  abort motion / clear fault
//   coil_o   coil drive {D,C,B,A}
//   busy_o   motion in progress (RUN or HOLD)
//   done_o   one-cycle success pulse
//   fault_o  jam fault level
interface dispense_step_ctrl_if #(
  parameter int STEPS_W = 12
);
  logic               req_i;
  logic [STEPS_W-1:0] steps_i;
  logic               abort_i;
  logic [3:0]         coil_o;
  logic               busy_o;
  logic               done_o;
  logic               fault_o;

  modport master (
    output req_i, steps_i, abort_i,
    input  coil_o, busy_o, done_o, fault_o
  );

  modport slave (
    input  req_i, steps_i, abort_i,
    output coil_o, busy_o, done_o, fault_o
  );
endinterface

// File: rtl/sync_edge_det.sv
// sync_edge_det: STAGES-deep synchroniser for an asynchronous input.
//   EDGE=1: q_o is a registered one-cycle pulse on a synced rising edge,
//           valid STAGES+1 cycles after the input rises.
//   EDGE=0: q_o is the synced level.
// Ports: clk, rst_n (async active-low), d_i (async input), q_o.
module sync_edge_det #(
  parameter int STAGES = 2,
  parameter bit EDGE   = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d_i};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  if (EDGE) begin : g_edge
    logic              prev_q, prev_d;
    logic              edge_q, edge_d;
    logic [STAGES:0]   vld_pipe, vld_pipe_d;

    // vld_pipe fills with ones after reset; its top bit means prev_q holds a
    // real sample. Until then no edge is reported, so a level already high
    // at reset release does not look like a rise.
    always_comb begin
      vld_pipe_d = {vld_pipe[STAGES-1:0], 1'b1};
      prev_d     = sync_q[STAGES-1];
      edge_d     = sync_q[STAGES-1] & ~prev_q & vld_pipe[STAGES];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_pipe <= '0;
        prev_q   <= 1'b0;
        edge_q   <= 1'b0;
      end else begin
        vld_pipe <= vld_pipe_d;
        prev_q   <= prev_d;
        edge_q   <= edge_d;
      end
    end

    assign q_o = edge_q;
  end else begin : g_level
    assign q_o = sync_q[STAGES-1];
  end

endmodule

// File: rtl/dispense_step_ctrl.sv
// dispense_step_ctrl: dispense-coil stepper sequencer.
//   Loads a step count on request, advances the coil pattern once per step
//   tick, holds the last pattern for HOLD_TICKS ticks, then reports done if
//   the IR drop sensor saw product, else enters FAULT until abort.
// Build option: HALF_STEP_EN selects the 8-entry half-step sequence.
// Ports:
//   clock_test    oscillator clock (only clock)
//   rstn          async active-low reset
//   tick_i        step-rate tick, asynchronous
//   drop_sense_i  IR drop sensor, asynchronous, high = product falling
//   bus           request/status interface (slave side)
module dispense_step_ctrl
  import dispense_pkg::*;
#(
  parameter int STEPS_W     = 12,
  parameter int SYNC_STAGES = 2,   // must be >= 2
  parameter int HOLD_TICKS  = 2    // must be >= 1
) (
  input  logic                 clock_test,
  input  logic                 rstn,
  input  logic                 tick_i,
  input  logic                 drop_sense_i,
  dispense_step_ctrl_if.slave  bus
);

  localparam int HOLD_W = $clog2(HOLD_TICKS + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);

  logic step_en;
  logic drop_lvl;

  sync_edge_det #(.STAGES(SYNC_STAGES), .EDGE(1'b1)) u_tick_sync (
    .clk   (clock_test),
    .rst_n (rstn),
    .d_i   (tick_i),
    .q_o   (step_en)
  );

  sync_edge_det #(.STAGES(SYNC_STAGES), .EDGE(1'b0)) u_drop_sync (
    .clk   (clock_test),
    .rst_n (rstn),
    .d_i   (drop_sense_i),
    .q_o   (drop_lvl)
  );

  state_e             state_q, state_d;
  phase_t             phase_q, phase_d;
  logic [STEPS_W-1:0] cnt_q, cnt_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               drop_seen_q, drop_seen_d;
  logic [3:0]         coil_q, coil_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               fault_q, fault_d;
  logic               moving;

  always_ff @(posedge clock_test or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      phase_q     <= '0;
      cnt_q       <= '0;
      hold_q      <= '0;
      drop_seen_q <= 1'b0;
      coil_q      <= COIL_OFF;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      drop_seen_q <= drop_seen_d;
      coil_q      <= coil_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fault_q     <= fault_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    done_d      = 1'b0;
    // The drop is latched in the same cycle it is seen so a drop that
    // arrives on the final hold tick still counts.
    drop_seen_d = drop_seen_q |
                  (drop_lvl & ((state_q == ST_RUN) || (state_q == ST_HOLD)));

    unique case (state_q)
      ST_IDLE: begin
        if (!bus.abort_i && bus.req_i) begin
          if (bus.steps_i != '0) begin
            cnt_d       = bus.steps_i;
            phase_d     = '0;
            drop_seen_d = 1'b0;
            state_d     = ST_RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (bus.abort_i) begin
          state_d = ST_IDLE;
        end else if (step_en) begin
          phase_d = phase_q + 1'b1;
          cnt_d   = cnt_q - 1'b1;
          if (cnt_q == STEPS_W'(1)) begin
            state_d = ST_HOLD;
            hold_d  = '0;
          end
        end
      end
      ST_HOLD: begin
        if (bus.abort_i) begin
          state_d = ST_IDLE;
        end else if (step_en) begin
          if (hold_q == HOLD_LAST) begin
            if (drop_seen_d) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_FAULT;
            end
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
      end
      ST_FAULT: begin
        if (bus.abort_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered from the next state so they change together
    // with the state and never glitch.
    moving  = (state_d == ST_RUN) || (state_d == ST_HOLD);
    coil_d  = moving ? seq_coil(phase_d) : COIL_OFF;
    busy_d  = moving;
    fault_d = (state_d == ST_FAULT);
  end

  assign bus.coil_o  = coil_q;
  assign bus.busy_o  = busy_q;
  assign bus.done_o  = done_q;
  assign bus.fault_o = fault_q;

endmodule

// File: doc/dispense_step_ctrl.md
Name: dispense_step_ctrl

Overview:
- Downstream consumer of clock_division: uses the divided clock (clock_div_o) as a step-rate tick for the dispense-coil stepper motor.
- Runs on the OSCH oscillator clock, ~2.08 MHz on MachXO2.
- Takes a dispense request with a step count, sequences the 4 coil phases one step per tick, and then checks the IR drop sensor.
- Reports done or jam fault to the vend controller.

Parameters:
- STEPS_W, 12, width of the step-count request.
- SYNC_STAGES, 2, synchroniser flops on tick_i and drop_sense_i (minimum 2).
- HOLD_TICKS, 2, step ticks the coils stay energised after the last step before the drop check.

Ports:
- clock_test  in  1  OSCH oscillator clock; the single clock of the block.
- rstn  in  1  asynchronous active-low reset.
- tick_i  in  1  divided clock from clock_division.clock_div_o; treated as asynchronous.
- req_i  in  1  dispense request level, sampled only in IDLE.
- steps_i  in  STEPS_W  number of motor steps; sampled with req_i.
- abort_i  in  1  abort motion or clear fault.
- drop_sense_i  in  1  IR beam sensor, high = product falling; asynchronous.
- coil_o  out  4  stepper coil drive {D,C,B,A}, registered.
- busy_o  out  1  high in RUN and HOLD.
- done_o  out  1  one-cycle success pulse.
- fault_o  out  1  high while in FAULT.

Behaviour:
- Clock and reset: one clock (clock_test); rstn is asynchronous, active-low. All flops reset asynchronously.
- Reset values:
  - state=IDLE, phase=0, cnt=0, drop_seen=0, synchroniser flops 0.
  - coil_o=4'b0000, busy_o=0, done_o=0, fault_o=0.
  - Reset mid-operation de-energises the coils immediately (asynchronous).
- Tick input:
  - tick_i passes through SYNC_STAGES flops, then rising-edge detect, giving a one-cycle step_en.
  - step_en fires SYNC_STAGES+1 clock_test cycles after the tick_i rise.
  - A level-high tick_i at reset release produces no step_en.
- Drop sensor:
  - drop_sense_i passes through SYNC_STAGES flops (level only).
  - drop_seen sets on any synced high in RUN or HOLD. It clears on load.
- IDLE:
  - coil_o=0.
  - req_i=1 and steps_i!=0: load cnt=steps_i, phase=0, drop_seen=0. Next cycle: state=RUN, busy_o=1, coil_o=SEQ[0].
  - req_i=1 and steps_i==0: done_o pulses the next cycle, state stays IDLE, no motion.
- RUN:
  - On each step_en: phase advances (mod sequence length), cnt decrements, coil_o updates the following cycle.
  - When cnt goes 1 to 0 on a step_en, go to HOLD with the last pattern held.
  - A total of steps_i step_en pulses completes RUN.
- HOLD:
  - Coils held for HOLD_TICKS step_en pulses.
  - Then, if drop_seen: coil_o=0, done_o pulses one cycle, go to IDLE.
  - Otherwise: coil_o=0, go to FAULT.
- FAULT: coil_o=0, fault_o=1, busy_o=0. Only abort_i leaves it (to IDLE, fault_o=0 the next cycle).
- abort_i in RUN/HOLD: next cycle state=IDLE, coil_o=0, busy_o=0, no done_o pulse.
- Priority:
  - abort_i beats step_en and beats req_i.
  - req_i is ignored outside IDLE; an early re-request is not queued.
  - A held req_i re-triggers in IDLE the cycle after done_o. The vend controller must drop req_i on busy_o.
- Full-step sequence, SEQ[0..3] = 0011, 0110, 1100, 1001. Two coils are on at all times.
- Coil outputs are glitch-free: every output is a flop.

Optional Feature:
- Macro HALF_STEP_EN.
- Defined: phase is 3 bits with an 8-entry sequence 0001, 0011, 0010, 0110, 0100, 1100, 1000, 1001. Each step_en advances one half-step. steps_i counts half-steps.
- Undefined: the 2-bit phase, 4-entry full-step sequence above.
- All other behaviour is identical.

Decomposition:
- Package/header dispense_pkg holds:
  - state encodings IDLE=0, RUN=1, HOLD=2, FAULT=3;
  - coil sequence constants for both modes, and sequence length/phase width selected by HALF_STEP_EN;
  - COIL_OFF=4'b0000.
- Sub-module sync_edge_det:
  - SYNC_STAGES-deep synchroniser with an optional rising-edge output, parameter EDGE=1/0.
  - Instantiated for tick_i (edge) and drop_sense_i (level).

Test Plan:
- Reset, then req_i=1 with steps_i=5, ticks every 16 cycles, drop pulse during step 3 → coil_o walks 0011, 0110, 1100, 1001, 0011, 0110; HOLD for 2 ticks; then one done_o pulse, coil_o=0, fault_o=0.
- steps_i=3 with no drop_sense → after 3 steps plus 2 hold ticks: fault_o=1, coil_o=0. A req_i while in fault is ignored; abort_i clears to IDLE.
- steps_i=0 with req_i=1 → done_o pulses the next cycle, busy_o never high, coil_o stays 0.
- abort_i asserted in the same cycle as step_en, mid-RUN at cnt=7 → next cycle IDLE, coil_o=0, no done_o, phase not advanced.
- rstn driven low asynchronously mid-RUN with coils energised → coil_o=0 immediately, with no clock edge required.
- With HALF_STEP_EN, steps_i=9 → coil_o cycles through all 8 half-step patterns and wraps back to 0001 on the 8th step_en, then 0011 on the 9th.
